// File: rtl/bitplane_dma.sv
// rtl/bitplane_dma.sv - bitplane DMA sequencer: DDF window, slot map, plane pointers and modulos
module bitplane_dma #(
  parameter int PTR_BITS = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          hpos,
  input  logic                vdiwen,
  input  logic                dmaena,
  input  logic [7:0]          regaddressin,
  input  logic [15:0]         datain,
  output logic                dma,
  output logic [7:0]          regaddressout,
  output logic [PTR_BITS:1]   addressout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  // register bus addresses are word addresses, i.e. the 9-bit offset shifted right by one
  localparam logic [7:0] A_DDFSTRT = 8'h49;
  localparam logic [7:0] A_DDFSTOP = 8'h4A;
  localparam logic [7:0] A_BPLCON0 = 8'h80;
  localparam logic [7:0] A_BPL1MOD = 8'h84;
  localparam logic [7:0] A_BPL2MOD = 8'h85;
  localparam logic [7:0] A_BPL1PTH = 8'h70;
  localparam logic [7:0] A_BPL0DAT = 8'h87;
  localparam logic [7:0] NO_REG    = 8'hFF;
  localparam logic [7:0] STOP_MAX  = 8'hD8;

  // programmed registers (only the bits the sequencer uses are kept)
  logic [5:0]          ddfstrt_r;
  logic [5:0]          ddfstop_r;
  logic                hires_r;
  logic [2:0]          bpu_r;
  logic [14:0]         mod1_r;
  logic [14:0]         mod2_r;
  logic [PTR_BITS:1]   ptr [0:5];

  // sequencer state
  logic [1:0]          state;
  logic [2:0]          cnt;
  logic                u_hires;
  logic [2:0]          u_bpu;

  // decode and datapath
  logic [5:0]          pth_wr;
  logic [5:0]          ptl_wr;
  logic [2:0]          bpu_live;
  logic [7:0]          start_pos;
  logic [7:0]          stop_raw;
  logic [7:0]          stop_pos;
  logic                start_match;
  logic                unit_start;
  logic                abort;
  logic                active;
  logic                final_unit;
  logic                cur_hires;
  logic [2:0]          cur_bpu;
  logic [2:0]          slot_plane;
  logic [2:0]          slot_idx;
  logic                fetch;
  logic                last_fetch;
  logic [14:0]         mod_sel;
  logic [PTR_BITS:1]   step;
  logic                unused_bits;

  assign unused_bits = datain[0];

  // pointer register decode: PTH/PTL pairs sit four bytes apart per plane
  always_comb begin
    pth_wr = '0;
    ptl_wr = '0;
    for (int i = 0; i < 6; i++) begin
      pth_wr[i] = (regaddressin == (A_BPL1PTH + 8'(2 * i)));
      ptl_wr[i] = (regaddressin == (A_BPL1PTH + 8'(2 * i + 1)));
    end
  end

  // effective plane count and fetch window from the live register values
  always_comb begin
    bpu_live = bpu_r;
    if (bpu_r == 3'd7 || (hires_r && bpu_r > 3'd4)) begin
      bpu_live = 3'd4;
    end
    start_pos = {ddfstrt_r, 2'b00};
    stop_raw  = {ddfstop_r, 2'b00};
    stop_pos  = (stop_raw > STOP_MAX) ? STOP_MAX : stop_raw;
  end

  // unit start detection; the live values govern the first cycle of a unit, the latched ones the rest
  always_comb begin
    start_match = (state == IDLE) && (hpos == start_pos) && vdiwen && dmaena && (bpu_live != 3'd0);
    abort       = (state == FETCH) && (cnt == 3'd0) && !(vdiwen && dmaena);
    unit_start  = start_match || ((state == FETCH) && (cnt == 3'd0));
    active      = start_match || (((state == FETCH) || (state == FLUSH)) && !abort);
    final_unit  = (hpos >= stop_pos);
    cur_hires   = unit_start ? hires_r  : u_hires;
    cur_bpu     = unit_start ? bpu_live : u_bpu;
  end

  // slot map: which plane (1..6, 0 = none) owns this cycle of the unit
  always_comb begin
    slot_plane = 3'd0;
    if (cur_hires) begin
      case (cnt[1:0])
        2'd0:    slot_plane = 3'd4;
        2'd1:    slot_plane = 3'd2;
        2'd2:    slot_plane = 3'd3;
        default: slot_plane = 3'd1;
      endcase
    end else begin
      case (cnt)
        3'd1:    slot_plane = 3'd4;
        3'd2:    slot_plane = 3'd6;
        3'd3:    slot_plane = 3'd2;
        3'd5:    slot_plane = 3'd3;
        3'd6:    slot_plane = 3'd5;
        3'd7:    slot_plane = 3'd1;
        default: slot_plane = 3'd0;
      endcase
    end
  end

  // fetch qualification and pointer step; odd planes use BPL1MOD, even planes BPL2MOD
  always_comb begin
    fetch      = active && (slot_plane != 3'd0) && (slot_plane <= cur_bpu);
    slot_idx   = slot_plane - 3'd1;
    // hires fetches each plane twice per unit, so only the second half carries the modulo
    last_fetch = (state == FLUSH) && (cur_hires ? cnt[2] : 1'b1);
    mod_sel    = slot_plane[0] ? mod1_r : mod2_r;
    step       = PTR_BITS'(1);
    if (last_fetch) begin
      step = PTR_BITS'(1) + {{(PTR_BITS - 15){mod_sel[14]}}, mod_sel};
    end
  end

  // control register writes
  always_ff @(posedge clk) begin
    if (reset) begin
      ddfstrt_r <= '0;
      ddfstop_r <= '0;
      hires_r   <= 1'b0;
      bpu_r     <= '0;
      mod1_r    <= '0;
      mod2_r    <= '0;
    end else begin
      case (regaddressin)
        A_DDFSTRT: ddfstrt_r <= datain[7:2];
        A_DDFSTOP: ddfstop_r <= datain[7:2];
        A_BPLCON0: begin
          hires_r <= datain[15];
          bpu_r   <= datain[14:12];
        end
        A_BPL1MOD: mod1_r <= datain[15:1];
        A_BPL2MOD: mod2_r <= datain[15:1];
        default: ;
      endcase
    end
  end

  // plane pointers: a bus write to a pointer suppresses the DMA update in the same cycle
  always_ff @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (reset) begin
        ptr[i] <= '0;
      end else if (pth_wr[i] || ptl_wr[i]) begin
        if (pth_wr[i]) ptr[i][PTR_BITS:16] <= datain[PTR_BITS-16:0];
        if (ptl_wr[i]) ptr[i][15:1]        <= datain[15:1];
      end else if (fetch && (slot_idx == 3'(i))) begin
        ptr[i] <= ptr[i] + step;
      end
    end
  end

  // line sequencer: IDLE -> FETCH -> FLUSH -> IDLE, one 8-cycle unit at a time
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      u_hires <= 1'b0;
      u_bpu   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (start_match) begin
            state   <= final_unit ? FLUSH : FETCH;
            cnt     <= 3'd1;
            u_hires <= hires_r;
            u_bpu   <= bpu_live;
          end
        end
        FETCH: begin
          if (cnt == 3'd0) begin
            if (abort) begin
              state <= IDLE;
            end else begin
              state   <= final_unit ? FLUSH : FETCH;
              cnt     <= 3'd1;
              u_hires <= hires_r;
              u_bpu   <= bpu_live;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        FLUSH: begin
          if (cnt == 3'd7) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  // registered bus request towards the arbiter, one cycle after the slot
  always_ff @(posedge clk) begin
    if (reset) begin
      dma           <= 1'b0;
      regaddressout <= NO_REG;
      addressout    <= '0;
    end else begin
      dma           <= fetch;
      regaddressout <= fetch ? (A_BPL0DAT + {5'b0, slot_plane}) : NO_REG;
      if (fetch) begin
        addressout <= ptr[slot_idx];
      end
    end
  end

endmodule

// File: tb/tb_bitplane_dma.sv
// tb/tb_bitplane_dma.sv - scoreboard bench for bitplane_dma
module tb_bitplane_dma;

  logic        clk;
  logic        reset;
  logic [7:0]  hpos;
  logic        vdiwen;
  logic        dmaena;
  logic [7:0]  regaddressin;
  logic [15:0] datain;
  logic        dma;
  logic [7:0]  regaddressout;
  logic [20:1] addressout;

  bitplane_dma #(.PTR_BITS(20)) dut (
    .clk(clk),
    .reset(reset),
    .hpos(hpos),
    .vdiwen(vdiwen),
    .dmaena(dmaena),
    .regaddressin(regaddressin),
    .datain(datain),
    .dma(dma),
    .regaddressout(regaddressout),
    .addressout(addressout)
  );

  typedef struct packed {
    logic [7:0]  h;
    logic [7:0]  ra;
    logic [19:0] ad;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;
  bit   mon_on;
  int   hord[4];
  int   lord[8];
  int   b[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h required %0h at hpos %0d", name, act, req, hpos);
  endtask

  function automatic void push(input int h, input int ra, input int ad);
    exp_t e;
    e.h  = h[7:0];
    e.ra = ra[7:0];
    e.ad = ad[19:0];
    exp_q.push_back(e);
  endfunction

  // monitor: every dma cycle must match the next expected fetch, every other cycle shows FF
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (dma) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_dma", {24'b0, regaddressout}, 32'hFF);
          end else begin
            e = exp_q.pop_front();
            chk(hpos == e.h, "dma_hpos", {24'b0, hpos}, {24'b0, e.h});
            chk(regaddressout == e.ra, "dma_regaddr", {24'b0, regaddressout}, {24'b0, e.ra});
            chk(addressout == e.ad, "dma_address", {12'b0, addressout}, {12'b0, e.ad});
          end
        end else begin
          chk(regaddressout == 8'hFF, "idle_regaddr", {24'b0, regaddressout}, 32'hFF);
        end
      end
    end
  end

  task automatic reg_wr(input logic [8:0] a, input logic [15:0] d);
    regaddressin = a[8:1];
    datain = d;
    @(posedge clk); #1;
    regaddressin = 8'hFF;
  endtask

  task automatic set_pt(input int x, input logic [31:0] byte_addr);
    logic [8:0] a;
    a = 9'h0E0 + 9'(4 * (x - 1));
    reg_wr(a, byte_addr[31:16]);
    reg_wr(a + 9'h002, byte_addr[15:0]);
  endtask

  task automatic run_line(input int wr_h, input logic [7:0] wr_a, input logic [15:0] wr_d, input int rst_h);
    vdiwen = 1'b1;
    for (int h = 0; h < 228; h++) begin
      hpos = h[7:0];
      regaddressin = (h == wr_h) ? wr_a : 8'hFF;
      datain = wr_d;
      reset = (h == rst_h);
      @(posedge clk); #1;
      if (h == rst_h) begin
        chk(dma == 1'b0, "reset_dma", {31'b0, dma}, 32'h0);
        chk(regaddressout == 8'hFF, "reset_regaddr", {24'b0, regaddressout}, 32'hFF);
        chk(addressout == 20'h0, "reset_address", {12'b0, addressout}, 32'h0);
      end
    end
    reset = 1'b0;
    regaddressin = 8'hFF;
    vdiwen = 1'b0;
    hpos = 8'hE4;
    @(posedge clk); #1;
    chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    mon_on = 1'b0;
    hord = '{4, 2, 3, 1};
    lord = '{0, 4, 6, 2, 0, 3, 5, 1};
    reset = 1'b1;
    hpos = 8'hE4;
    vdiwen = 1'b0;
    dmaena = 1'b1;
    regaddressin = 8'hFF;
    datain = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk(dma == 1'b0, "init_dma", {31'b0, dma}, 32'h0);
    chk(regaddressout == 8'hFF, "init_regaddr", {24'b0, regaddressout}, 32'hFF);
    chk(addressout == 20'h0, "init_address", {12'b0, addressout}, 32'h0);
    reset = 1'b0;
    mon_on = 1'b1;

    // lores, one plane, 20 units per line, pointer advances 20 words per line
    reg_wr(9'h100, 16'h1000);
    reg_wr(9'h092, 16'h0038);
    reg_wr(9'h094, 16'h00D0);
    set_pt(1, 32'h10000);
    for (int l = 0; l < 2; l++) begin
      for (int k = 0; k < 20; k++) push(64 + 8 * k, 8'h88, 32'h8000 + 20 * l + k);
      run_line(-1, 8'hFF, 16'h0, -1);
    end

    // hires, four planes, modulos +2 words (odd) and -1 word (even)
    reg_wr(9'h100, 16'hC000);
    reg_wr(9'h092, 16'h003C);
    reg_wr(9'h094, 16'h00D4);
    reg_wr(9'h108, 16'h0004);
    reg_wr(9'h10A, 16'hFFFE);
    for (int x = 1; x <= 4; x++) set_pt(x, 32'h1000 * x);
    b = '{32'h800, 32'h1000, 32'h1800, 32'h2000, 0, 0};
    for (int k = 0; k < 20; k++)
      for (int c = 0; c < 8; c++)
        push(61 + 8 * k + c, 8'h87 + hord[c % 4], b[hord[c % 4] - 1] + 2 * k + c / 4);
    run_line(-1, 8'hFF, 16'h0, -1);
    // line 2 bases: odd +84 bytes (42 words), even +78 bytes (39 words)
    b = '{32'h82A, 32'h1027, 32'h182A, 32'h2027, 0, 0};
    for (int k = 0; k < 20; k++)
      for (int c = 0; c < 8; c++)
        push(61 + 8 * k + c, 8'h87 + hord[c % 4], b[hord[c % 4] - 1] + 2 * k + c / 4);
    run_line(-1, 8'hFF, 16'h0, -1);

    // lores six planes, single-unit line; second line shows modulo after one fetch each
    reg_wr(9'h100, 16'h6000);
    reg_wr(9'h092, 16'h0038);
    reg_wr(9'h094, 16'h0038);
    for (int x = 1; x <= 6; x++) set_pt(x, 32'h1000 * x);
    for (int c = 1; c < 8; c++)
      if (lord[c] != 0) push(57 + c, 8'h87 + lord[c], 32'h800 * lord[c]);
    run_line(-1, 8'hFF, 16'h0, -1);
    for (int c = 1; c < 8; c++)
      if (lord[c] != 0) push(57 + c, 8'h87 + lord[c], 32'h800 * lord[c] + ((lord[c] % 2 == 1) ? 3 : 0));
    run_line(-1, 8'hFF, 16'h0, -1);

    // no fetch with bpu=0, nor with DMA disabled
    reg_wr(9'h100, 16'h0000);
    run_line(-1, 8'hFF, 16'h0, -1);
    reg_wr(9'h100, 16'h6000);
    dmaena = 1'b0;
    run_line(-1, 8'hFF, 16'h0, -1);
    dmaena = 1'b1;

    // lores bpu=7 behaves as four planes
    reg_wr(9'h100, 16'h7000);
    b = '{32'h806, 32'h1000, 32'h1806, 32'h2000, 0, 0};
    for (int c = 1; c < 8; c++)
      if (lord[c] != 0 && lord[c] <= 4) push(57 + c, 8'h87 + lord[c], b[lord[c] - 1]);
    run_line(-1, 8'hFF, 16'h0, -1);

    // hires with bpu=6: four planes, first dma at start+1
    reg_wr(9'h100, 16'hE000);
    b = '{32'h809, 32'h1000, 32'h1809, 32'h2000, 0, 0};
    for (int c = 0; c < 8; c++) push(57 + c, 8'h87 + hord[c % 4], b[hord[c % 4] - 1] + c / 4);
    run_line(-1, 8'hFF, 16'h0, -1);

    // PTL write colliding with the plane-1 fetch keeps the written value
    reg_wr(9'h100, 16'h1000);
    set_pt(1, 32'h100);
    push(64, 8'h88, 32'h80);
    run_line(63, 8'h71, 16'h1234, -1);
    push(64, 8'h88, 32'h91A);
    run_line(-1, 8'hFF, 16'h0, -1);

    // DDFSTOP beyond D8 is clamped: last unit at D8, last dma at E0
    reg_wr(9'h094, 16'h00E0);
    set_pt(1, 32'h20000);
    for (int k = 0; k < 21; k++) push(64 + 8 * k, 8'h88, 32'h10000 + k);
    run_line(-1, 8'hFF, 16'h0, -1);

    // reset mid-line stops fetching and clears every register
    reg_wr(9'h094, 16'h00D0);
    set_pt(1, 32'h200);
    for (int k = 0; k < 5; k++) push(64 + 8 * k, 8'h88, 32'h100 + k);
    run_line(-1, 8'hFF, 16'h0, 100);
    run_line(-1, 8'hFF, 16'h0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
